// File: rtl/cursor_pkg.sv
// Shared cursor/brush definitions: FSM states, screen geometry and the
// signed coordinate type used by the cursor, radius check and display path.
package cursor_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } cursor_state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef logic signed [15:0] coord_t;

endpackage

// File: rtl/btn_sync.sv
// Four-bit, two-flop synchroniser for the raw direction buttons.
// Both flops clear on reset so a held button is seen as a fresh press.
module btn_sync (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] btn_raw,
    output logic [3:0] btn_s
);

    logic [3:0] sync_p0;
    logic [3:0] sync_p1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    assign btn_s = sync_p1;

endmodule

// File: rtl/cursor_ctrl.sv
// Cursor position controller: synchronised buttons drive a press/hold/repeat
// FSM that steps the brush centre one pixel at a time, clamped to the screen.
module cursor_ctrl
    import cursor_pkg::*;
#(
    parameter int X_MAX         = SCREEN_W - 1,
    parameter int Y_MAX         = SCREEN_H - 1,
    parameter int X_INIT        = 320,
    parameter int Y_INIT        = 240,
    parameter int HOLD_CYCLES   = 8_000_000,
    parameter int REPEAT_CYCLES = 1_000_000
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   btn_up,
    input  logic   btn_down,
    input  logic   btn_left,
    input  logic   btn_right,
    output coord_t x1,
    output coord_t y1,
    output logic   step_pulse
);

    localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    // Sum is 17 bits wide, so clamping alone bounds the result.
    function automatic coord_t clamp_coord(input logic signed [16:0] v, input int hi);
        if (v < 0)
            return '0;
        else if (v > hi)
            return coord_t'(hi);
        else
            return v[15:0];
    endfunction

    logic [3:0] s_btn;
    logic       s_up, s_down, s_left, s_right;
    logic       any;
    logic signed [1:0]  ndx, ndy;
    logic signed [16:0] x_sum, y_sum;
    coord_t     x_nx, y_nx;

    cursor_state_t    state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             step;

    btn_sync u_btn_sync (
        .clock   (clock),
        .reset   (reset),
        .btn_raw ({btn_right, btn_left, btn_down, btn_up}),
        .btn_s   (s_btn)
    );

    assign {s_right, s_left, s_down, s_up} = s_btn;
    assign any = |s_btn;

    // y grows downward, so "down" is the positive direction.
    assign ndx = $signed({1'b0, s_right}) - $signed({1'b0, s_left});
    assign ndy = $signed({1'b0, s_down})  - $signed({1'b0, s_up});

    assign x_sum = 17'(x1) + 17'(ndx);
    assign y_sum = 17'(y1) + 17'(ndy);
    assign x_nx  = clamp_coord(x_sum, X_MAX);
    assign y_nx  = clamp_coord(y_sum, Y_MAX);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        step     = 1'b0;
        case (state)
            IDLE: begin
                if (any) begin
                    step     = 1'b1;
                    state_nx = HOLD;
                    cnt_nx   = '0;
                end
            end
            HOLD: begin
                if (!any) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == HOLD_LAST) begin
                    step     = 1'b1;
                    state_nx = REPEAT;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            REPEAT: begin
                if (!any) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == REPEAT_LAST) begin
                    step   = 1'b1;
                    cnt_nx = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // A step that lands on the same position (clamp or opposing buttons)
    // still advances the FSM but raises no pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            x1         <= coord_t'(X_INIT);
            y1         <= coord_t'(Y_INIT);
            step_pulse <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            step_pulse <= step && ((x_nx != x1) || (y_nx != y1));
            if (step) begin
                x1 <= x_nx;
                y1 <= y_nx;
            end
        end
    end

endmodule
